// File: rtl/display_scan_if.sv
// display_scan_if: value/load inputs and digit/position outputs of the scan controller
interface display_scan_if;
    logic        load;
    logic [31:0] value;
    logic        lz_en;
    logic [3:0]  dig;
    logic [2:0]  pos;
    logic        blank;
    logic        frame;
    modport master (output load, value, lz_en, input dig, pos, blank, frame);
    modport slave  (input load, value, lz_en, output dig, pos, blank, frame);
endinterface

// File: rtl/display_scan.sv
// display_scan: 8-digit seven-segment scan controller with frame-aligned double buffering
module display_scan #(
    parameter int SCAN_DIV = 100000
) (
    input logic           clk,
    input logic           rst_n,
    display_scan_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    logic [CW-1:0] cnt;
    logic [2:0]    pos_q;
    logic [31:0]   pend_val, disp_val, hi;
    logic          pend_flag, frame_q, tick, wrap;
    assign tick = cnt == CW'(SCAN_DIV - 1);
    assign wrap = tick && pos_q == 3'd7;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pos_q     <= '0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            disp_val  <= '0;
            frame_q   <= 1'b0;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            pos_q     <= tick ? pos_q + 3'd1 : pos_q;
            frame_q   <= wrap;
            pend_val  <= bus.load ? bus.value : pend_val;
            // a load coinciding with the wrap bypasses the pending buffer
            pend_flag <= wrap ? 1'b0 : (bus.load | pend_flag);
            disp_val  <= !wrap ? disp_val : bus.load ? bus.value : pend_flag ? pend_val : disp_val;
        end
    end
    assign hi        = disp_val >> {pos_q, 2'b00};
    assign bus.dig   = disp_val[{pos_q, 2'b00} +: 4];
    assign bus.pos   = pos_q;
    assign bus.blank = bus.lz_en && pos_q != 3'd0 && hi == 32'd0;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed checks of scan timing, buffering, blanking and reset with SCAN_DIV=4
module tb_display_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    display_scan_if bus();
    display_scan #(.SCAN_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_load(input logic [31:0] v);
        bus.load = 1'b1;
        bus.value = v;
        step(1);
        bus.load = 1'b0;
    endtask
    task automatic wait_frame();
        int n = 0;
        while (!bus.frame && n < 100) begin
            step(1);
            n++;
        end
        check("wait_frame", {31'd0, bus.frame}, 32'd1);
    endtask
    // entered on the first cycle of a frame; leaves on the first cycle of the next
    task automatic read_frame(input string tag, input logic [31:0] v, input logic [7:0] bmask);
        logic [31:0] t;
        t = v;
        for (int k = 0; k < 8; k++) begin
            check({tag, "_pos"}, {29'd0, bus.pos}, k);
            check({tag, "_dig"}, {28'd0, bus.dig}, {28'd0, t[3:0]});
            check({tag, "_blank"}, {31'd0, bus.blank}, {31'd0, bmask[k]});
            check({tag, "_frame"}, {31'd0, bus.frame}, (k == 0) ? 32'd1 : 32'd0);
            t = t >> 4;
            step(4);
        end
    endtask
    initial begin
        bus.load = 1'b0;
        bus.value = '0;
        bus.lz_en = 1'b0;
        step(1);
        check("rst_pos", {29'd0, bus.pos}, 0);
        check("rst_dig", {28'd0, bus.dig}, 0);
        check("rst_blank", {31'd0, bus.blank}, 0);
        check("rst_frame", {31'd0, bus.frame}, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("e3_pos", {29'd0, bus.pos}, 0);
        check("e3_dig", {28'd0, bus.dig}, 0);
        step(1);
        check("e4_pos", {29'd0, bus.pos}, 1);
        step(27);
        check("e31_pos", {29'd0, bus.pos}, 7);
        check("e31_frame", {31'd0, bus.frame}, 0);
        step(1);
        check("e32_pos", {29'd0, bus.pos}, 0);
        check("e32_frame", {31'd0, bus.frame}, 1);
        step(12);
        check("mid_pos3", {29'd0, bus.pos}, 3);
        do_load(32'h89AB_CDEF);
        check("mid_hold3", {28'd0, bus.dig}, 0);
        step(3);
        for (int p = 4; p < 8; p++) begin
            check("mid_pos", {29'd0, bus.pos}, p);
            check("mid_hold", {28'd0, bus.dig}, 0);
            step(4);
        end
        read_frame("mid", 32'h89AB_CDEF, 8'h00);
        bus.lz_en = 1'b1;
        do_load(32'h0000_0120);
        wait_frame();
        read_frame("lz120", 32'h0000_0120, 8'hF8);
        do_load(32'h0000_0000);
        wait_frame();
        read_frame("lz0", 32'h0000_0000, 8'hFE);
        bus.lz_en = 1'b0;
        step(31);
        check("wrap_pre_pos", {29'd0, bus.pos}, 7);
        do_load(32'h1234_5678);
        check("wrap_pos", {29'd0, bus.pos}, 0);
        check("wrap_dig", {28'd0, bus.dig}, 8);
        check("wrap_frame", {31'd0, bus.frame}, 1);
        check("wrap_pend", {31'd0, dut.pend_flag}, 0);
        read_frame("wrap", 32'h1234_5678, 8'h00);
        step(5);
        do_load(32'h1111_1111);
        step(6);
        do_load(32'h2222_2222);
        wait_frame();
        read_frame("b2b", 32'h2222_2222, 8'h00);
        do_load(32'hFFFF_FFFF);
        wait_frame();
        step(20);
        check("rmf_pos5", {29'd0, bus.pos}, 5);
        check("rmf_dig5", {28'd0, bus.dig}, 32'hF);
        do_load(32'hAAAA_AAAA);
        #1 rst_n = 1'b0;
        #1;
        check("rmf_async_pos", {29'd0, bus.pos}, 0);
        check("rmf_async_dig", {28'd0, bus.dig}, 0);
        step(1);
        bus.load = 1'b1;
        bus.value = 32'h5555_5555;
        step(1);
        bus.load = 1'b0;
        rst_n = 1'b1;
        step(3);
        check("rmf_e3_pos", {29'd0, bus.pos}, 0);
        check("rmf_e3_dig", {28'd0, bus.dig}, 0);
        step(1);
        check("rmf_e4_pos", {29'd0, bus.pos}, 1);
        wait_frame();
        read_frame("rmf", 32'h0000_0000, 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexing scan controller for the 8-digit seven-segment display. It holds a 32-bit hex value, cycles the active position 0..7 at a programmable refresh rate, and presents one nibble plus its position per slot to the digit/position decoder stage downstream. Leading-zero suppression is optional. New values are double-buffered so that one frame never mixes old and new digits.

## Interface
- SCAN_DIV, 100000: clock cycles per digit slot, ≥2. At 100 MHz this gives 1 kHz per digit and 125 Hz per frame.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- load  in  1  one-cycle strobe; captures `value` into the pending buffer
- value  in  32  eight hex digits; nibble k (`value[4k+3:4k]`) shows at position k
- lz_en  in  1  1 = blank leading zero digits above position 0
- dig  out  4  nibble for the current position; feeds the decoder's digit input
- pos  out  3  current position 0..7; feeds the decoder's position input
- blank  out  1  1 = current position must be dark; the top level forces all anode selects high when set
- frame  out  1  one-cycle pulse when the position wraps 7→0

## Operation
- Prescaler `cnt` (width `$clog2(SCAN_DIV)`):
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - `tick` = (cnt == SCAN_DIV-1).
- Position register `pos`:
  - Increments on each tick.
  - Wraps 7→0.
  - Never skips or repeats a position.
- Buffers:
  - `pend_val[31:0]` and `pend_flag` form the pending buffer.
  - `disp_val[31:0]` is the displayed value.
- Load rules:
  - `load`=1 sets `pend_val <= value` and `pend_flag <= 1`.
  - A later load in the same frame overwrites `pend_val`; last load wins.
- Swap at frame wrap (tick with pos==7):
  - If `load`=1 in the same cycle, `disp_val <= value` (bypass) and `pend_flag <= 0`.
  - Otherwise, if `pend_flag`=1, `disp_val <= pend_val` and `pend_flag <= 0`.
  - Otherwise `disp_val` is held.
- `disp_val` changes only on the edge where pos becomes 0. No mid-frame update is permitted.
- `dig` = `disp_val[4*pos+3 : 4*pos]`, combinational from registered pos and disp_val.
- Leading-zero suppression:
  - `blank` = lz_en AND (pos != 0) AND (all nibbles at index ≥ pos are 0).
  - Position 0 is never blanked; value 0 shows a single "0".
  - With lz_en=0, `blank` is always 0.
- `frame`: registered, high for exactly the one cycle after the 7→0 edge, i.e. the first cycle with pos==0 of each frame.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - cnt=0, pos=0, pend_val=0, pend_flag=0, disp_val=0.
  - Outputs: dig=0, pos=0, blank=0, frame=0.
- After rst_n rises, pos changes on the SCAN_DIV-th rising edge. Each slot is exactly SCAN_DIV cycles; a frame is 8·SCAN_DIV cycles.
- Load-to-display latency: from the load edge to the next 7→0 edge, between 1 and 8·SCAN_DIV cycles.
- The first frame slot always shows the new value at pos 0.
- Asserting rst_n mid-frame discards the pending value and restarts the scan at pos 0. The first slot after reset is a full SCAN_DIV cycles.
- `load` asserted during reset is ignored.
- Outputs `dig` and `blank` may change only on clock edges where pos changes or disp_val swaps.

## Test plan
All scenarios use SCAN_DIV=4.
- **Reset:** hold rst_n low 3 cycles, then release. Required: pos=0 and dig=0 for the first 4 edges, pos=1 after edge 4, frame pulses once after edge 32 with pos=0.
- **Mid-frame load:** load 0x89ABCDEF while pos=3. Required: dig stays 0 for pos 3..7. The next frame shows dig = F,E,D,C,B,A,9,8 for pos 0..7, with blank=0 throughout.
- **Leading-zero blanking:** lz_en=1, value 0x00000120. Required: blank=0 at pos 0..2 with dig=0,2,1, and blank=1 at pos 3..7. Then value 0x00000000: blank=0 only at pos 0 with dig=0.
- **Load on wrap:** load 0x12345678 in the same cycle as the tick with pos==7. Required: on the following cycle pos=0, dig=8, frame=1, and pend_flag=0.
- **Back-to-back loads:** load 0x11111111, then 0x22222222 in the same frame. Required: the next frame shows dig=2 at every position, and the value 1 never appears.
- **Reset mid-frame:** with 0xFFFFFFFF displayed, drop rst_n at pos 5 and also issue a load of 0xAAAAAAAA before reset. Required: pos=0 and dig=0 immediately. After release, the display shows 0 (the pending value is lost) until a new load.
